// File: rtl/sv_accum_pkg.sv
// Shared types and the clamp helper used by both the step counter and the result datapath.
package sv_accum_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        ARITH_WRAP = 1'b0,
        ARITH_SAT  = 1'b1
    } arith_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // raw is an unsigned sum with headroom; result is wrapped or clamped to 'width' bits.
    function automatic logic [MAX_W-1:0] sat_add(
        input logic [MAX_W+1:0] raw,
        input int               width,
        input arith_mode_e      mode
    );
        logic [MAX_W+1:0] lim;
        lim = ((MAX_W+2)'(1) << width) - (MAX_W+2)'(1);
        if (mode == ARITH_SAT && raw > lim) begin
            return lim[MAX_W-1:0];
        end
        return raw[MAX_W-1:0] & lim[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/sv_step_counter.sv
// Programmable up/down step counter with clear, load and wrap/saturate bounds.
module sv_step_counter
    import sv_accum_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              adv,
    input  logic [STEP_W-1:0] step,
    input  logic              down,
    input  logic              sat,
    output logic [WIDTH-1:0]  cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH+1:0] w_up_raw;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH:0]   w_dn_raw;
    arith_mode_e      w_mode;
    dir_e             w_dir;

    assign w_mode   = arith_mode_e'(sat);
    assign w_dir    = dir_e'(down);
    assign w_up_raw = (WIDTH+2)'(r_cnt) + (WIDTH+2)'(step);
    assign w_up     = WIDTH'(sat_add((MAX_W+2)'(w_up_raw), WIDTH, w_mode));
    // Top bit of the extended difference is the borrow, i.e. the count went below zero.
    assign w_dn_raw = (WIDTH+1)'(r_cnt) - (WIDTH+1)'(step);

    always_comb begin
        w_cnt_next = r_cnt;
        if (clr) begin
            w_cnt_next = '0;
        end else if (load) begin
            w_cnt_next = load_val;
        end else if (adv) begin
            if (w_dir == DIR_DOWN) begin
                if (w_mode == ARITH_SAT && w_dn_raw[WIDTH]) begin
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = w_dn_raw[WIDTH-1:0];
                end
            end else begin
                w_cnt_next = w_up;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/sv_step_accum.sv
// Handshaked accumulator: registered result = a + b + running counter, with overflow flag.
module sv_step_accum
    import sv_accum_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter int FREE_RUN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_sum,
    output logic              out_ovf,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic              cfg_down,
    input  logic              cfg_sat,
    input  logic              cnt_clr,
    input  logic              cnt_load,
    input  logic [WIDTH-1:0]  cnt_load_val,
    output logic [WIDTH-1:0]  cnt_val
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_ovf;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_adv;
    logic [WIDTH-1:0] w_cnt;
    logic [WIDTH+1:0] w_raw;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sum;

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_adv      = (FREE_RUN != 0) ? 1'b1 : w_accept;

    // The counter's pre-update value feeds the sum, so clr/load never affect this result.
    assign w_raw = (WIDTH+2)'(in_a) + (WIDTH+2)'(in_b) + (WIDTH+2)'(w_cnt);
    assign w_ovf = |w_raw[WIDTH+1:WIDTH];
    assign w_sum = WIDTH'(sat_add((MAX_W+2)'(w_raw), WIDTH, arith_mode_e'(cfg_sat)));

    sv_step_counter #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .adv      (w_adv),
        .step     (cfg_step),
        .down     (cfg_down),
        .sat      (cfg_sat),
        .cnt      (w_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum;
            r_out_ovf   <= w_ovf;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign cnt_val   = w_cnt;

endmodule

// File: tb/tb_sv_step_accum.sv
// Bench for sv_step_accum: directed vector table, handshake sequences, random run against an integer model.
module tb_sv_step_accum;

    localparam int W    = 8;
    localparam int SW   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [W-1:0]  in_a, in_b, out_sum, cnt_load_val, cnt_val;
    logic [SW-1:0] cfg_step;
    logic          cfg_down, cfg_sat, cnt_clr, cnt_load;

    logic          in_valid_f, in_ready_f, out_valid_f, out_ready_f, out_ovf_f;
    logic [W-1:0]  in_a_f, in_b_f, out_sum_f, cnt_val_f;
    logic [SW-1:0] cfg_step_f;

    sv_step_accum #(.WIDTH(W), .STEP_W(SW), .FREE_RUN(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .cfg_step(cfg_step), .cfg_down(cfg_down),
        .cfg_sat(cfg_sat), .cnt_clr(cnt_clr), .cnt_load(cnt_load),
        .cnt_load_val(cnt_load_val), .cnt_val(cnt_val)
    );

    sv_step_accum #(.WIDTH(W), .STEP_W(SW), .FREE_RUN(1)) dut_free (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_f), .in_ready(in_ready_f),
        .in_a(in_a_f), .in_b(in_b_f), .out_valid(out_valid_f), .out_ready(out_ready_f),
        .out_sum(out_sum_f), .out_ovf(out_ovf_f), .cfg_step(cfg_step_f), .cfg_down(1'b0),
        .cfg_sat(1'b0), .cnt_clr(1'b0), .cnt_load(1'b0),
        .cnt_load_val('0), .cnt_val(cnt_val_f)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: the result register contents and counter, as plain integers.
    int m_valid, m_sum, m_ovf, m_cnt;

    typedef struct {
        int a, b, step, down, sat, clr, load, lval;
        int sum, ovf, cnt;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_sum = 0; m_ovf = 0; m_cnt = 0;
    endtask

    // Predict from the current inputs, advance one clock, then compare every output.
    task automatic tick();
        int acc, raw, nv, ns, no, nc, c;
        acc = (in_valid && (m_valid == 0 || out_ready)) ? 1 : 0;
        nv = m_valid; ns = m_sum; no = m_ovf; nc = m_cnt;
        if (acc != 0) begin
            raw = int'(in_a) + int'(in_b) + m_cnt;
            no  = (raw > MAXV) ? 1 : 0;
            ns  = (no != 0 && cfg_sat) ? MAXV : raw % (MAXV + 1);
            nv  = 1;
        end else if (m_valid != 0 && out_ready) begin
            nv = 0;
        end
        if (cnt_clr) begin
            nc = 0;
        end else if (cnt_load) begin
            nc = int'(cnt_load_val);
        end else if (acc != 0) begin
            c = cfg_down ? m_cnt - int'(cfg_step) : m_cnt + int'(cfg_step);
            if (cfg_sat) c = (c < 0) ? 0 : ((c > MAXV) ? MAXV : c);
            else         c = (c + MAXV + 1) % (MAXV + 1);
            nc = c;
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_sum = ns; m_ovf = no; m_cnt = nc;
        chk("out_valid", int'(out_valid), m_valid);
        chk("cnt_val", int'(cnt_val), m_cnt);
        if (m_valid != 0) begin
            chk("out_sum", int'(out_sum), m_sum);
            chk("out_ovf", int'(out_ovf), m_ovf);
        end
        chk("in_ready", int'(in_ready), (m_valid == 0 || out_ready) ? 1 : 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_cnt_val", int'(cnt_val), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 0; in_a = '0; in_b = '0; out_ready = 1;
        cfg_step = '0; cfg_down = 0; cfg_sat = 0;
        cnt_clr = 0; cnt_load = 0; cnt_load_val = '0;
        in_valid_f = 0; in_a_f = '0; in_b_f = '0; out_ready_f = 1; cfg_step_f = '0;
        #1;
        do_reset();

        //            a    b  step dn sat clr ld lval   sum ovf cnt
        vt[0]  = '{   1,   2, 2, 0, 0, 0, 0,   0,    3, 0,   2};
        vt[1]  = '{   1,   2, 2, 0, 0, 0, 0,   0,    5, 0,   4};
        vt[2]  = '{   1,   2, 2, 0, 0, 0, 0,   0,    7, 0,   6};
        vt[3]  = '{  10,  10, 2, 0, 0, 1, 0,   0,   26, 0,   0};
        vt[4]  = '{ 200, 100, 0, 0, 0, 0, 0,   0,   44, 1,   0};
        vt[5]  = '{ 200, 100, 0, 0, 1, 0, 0,   0,  255, 1,   0};
        vt[6]  = '{   5,   5, 2, 0, 0, 0, 1,  50,   10, 0,  50};
        vt[7]  = '{   5,   5, 2, 0, 0, 1, 1,  50,   60, 0,   0};
        vt[8]  = '{   0,   0, 0, 0, 0, 0, 1, 254,    0, 0, 254};
        vt[9]  = '{   0,   0, 3, 0, 0, 0, 0,   0,  254, 0,   1};
        vt[10] = '{   0,   0, 0, 0, 0, 0, 1, 254,    1, 0, 254};
        vt[11] = '{   0,   0, 3, 0, 1, 0, 0,   0,  254, 0, 255};
        vt[12] = '{   0,   0, 0, 0, 0, 0, 1,   1,  255, 0,   1};
        vt[13] = '{   0,   0, 3, 1, 1, 0, 0,   0,    1, 0,   0};
        vt[14] = '{   0,   0, 0, 0, 0, 0, 1,   1,    0, 0,   1};
        vt[15] = '{   0,   0, 3, 1, 0, 0, 0,   0,    1, 0, 254};
        vt[16] = '{   1,   1, 0, 0, 1, 0, 0,   0,  255, 1, 254};

        out_ready = 1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1; in_a = W'(vt[i].a); in_b = W'(vt[i].b);
            cfg_step = SW'(vt[i].step); cfg_down = vt[i].down[0]; cfg_sat = vt[i].sat[0];
            cnt_clr = vt[i].clr[0]; cnt_load = vt[i].load[0]; cnt_load_val = W'(vt[i].lval);
            tick();
            $display("vec %0d: a=%0d b=%0d -> sum=%0d ovf=%0d cnt=%0d", i, vt[i].a, vt[i].b,
                     out_sum, out_ovf, cnt_val);
            chk("tbl_valid", int'(out_valid), 1);
            chk("tbl_sum", int'(out_sum), vt[i].sum);
            chk("tbl_ovf", int'(out_ovf), vt[i].ovf);
            chk("tbl_cnt", int'(cnt_val), vt[i].cnt);
        end
        in_valid = 0; cnt_clr = 0; cnt_load = 0; cfg_sat = 0; cfg_down = 0;
        tick();

        // Backpressure: result holds and counter freezes while the consumer stalls.
        do_reset();
        cfg_step = 1; in_valid = 1; in_a = 3; in_b = 4; out_ready = 0;
        tick();
        chk("bp_sum", int'(out_sum), 7);
        chk("bp_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_sum", int'(out_sum), 7);
            chk("bp_hold_cnt", int'(cnt_val), 1);
        end
        out_ready = 1; in_a = 10; in_b = 0;
        #1;
        chk("bp_release_ready", int'(in_ready), 1);
        tick();
        chk("bp_next_sum", int'(out_sum), 11);
        in_valid = 0;
        tick();
        chk("bp_drained", int'(out_valid), 0);
        $display("backpressure sequence done: cnt=%0d", cnt_val);

        for (int i = 0; i < 400; i++) begin
            in_valid     = ($urandom % 4) != 0;
            out_ready    = ($urandom % 3) != 0;
            in_a         = W'($urandom);
            in_b         = W'($urandom);
            cfg_step     = SW'($urandom);
            cfg_down     = 1'($urandom);
            cfg_sat      = 1'($urandom);
            cnt_clr      = ($urandom % 16) == 0;
            cnt_load     = ($urandom % 16) == 1;
            cnt_load_val = W'($urandom);
            tick();
            $display("rnd %0d: v=%0d r=%0d sum=%0d ovf=%0d cnt=%0d", i, out_valid, out_ready,
                     out_sum, out_ovf, cnt_val);
        end
        in_valid = 0; cnt_clr = 0; cnt_load = 0; out_ready = 1;
        tick();

        // Free-running instance advances without any input traffic.
        do_reset();
        cfg_step = 0; cfg_down = 0; cfg_sat = 0;
        cfg_step_f = 1;
        repeat (10) @(posedge clk);
        #1;
        cfg_step_f = 0;
        chk("free_cnt", int'(cnt_val_f), 10);
        $display("free-run: cnt=%0d after 10 cycles", cnt_val_f);

        // Fill both output registers, then assert reset in the middle of a cycle.
        in_valid_f = 1; in_a_f = 5; in_b_f = 6; out_ready_f = 0;
        in_valid = 1; in_a = 1; in_b = 1; out_ready = 0; cnt_load = 1; cnt_load_val = 77;
        tick();
        in_valid_f = 0; in_valid = 0; cnt_load = 0;
        chk("free_pend_valid", int'(out_valid_f), 1);
        chk("free_pend_sum", int'(out_sum_f), 21);
        chk("pend_cnt", int'(cnt_val), 77);
        #2;
        rst_n = 0;
        #1;
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_out_sum", int'(out_sum), 0);
        chk("async_cnt_val", int'(cnt_val), 0);
        chk("async_free_valid", int'(out_valid_f), 0);
        chk("async_free_sum", int'(out_sum_f), 0);
        chk("async_free_cnt", int'(cnt_val_f), 0);
        $display("async reset: valid=%0d cnt=%0d free_valid=%0d free_cnt=%0d", out_valid,
                 cnt_val, out_valid_f, cnt_val_f);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 1;
        tick();
        chk("post_rst_valid", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
